dpr_fifo_ctrl: RTL and testbench
================================

Name: dpr_fifo_ctrl

Overview:
- Synchronous FIFO controller that acts as the initiator for the existing DualPortRam (64 x 8).
- Port A is used only for writes; port B is used only for reads.
- Converts push/pop requests into RAM address, data and write-enable drive, and maintains pointers, occupancy and flags.
- Sits between a producer and a consumer; the RAM is instantiated alongside it in a wrapper.

Parameters:
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.
- DATA_W, 8, data word width; must match DualPortRam.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as rst on FIFO state.
- wr_en  in  1  push request.
- wr_data  in  DATA_W  push data.
- full  out  1  FIFO holds 64 words.
- rd_en  in  1  pop request.
- rd_data  out  DATA_W  popped word; meaningful only while rd_valid=1.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.
- empty  out  1  FIFO holds 0 words.
- count  out  ADDR_W+1  occupancy, 0..64.
- ram_data_a  out  DATA_W  to DualPortRam data_a.
- ram_addr_a  out  ADDR_W  to addr_a.
- ram_we_a  out  1  to we_a.
- ram_data_b  out  DATA_W  to data_b; tied 0.
- ram_addr_b  out  ADDR_W  to addr_b.
- ram_we_b  out  1  to we_b; tied 0.
- ram_q_b  in  DATA_W  from q_b; registered read, 1-cycle latency.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset state (rst=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0.
  - rd_data is a combinational pass-through of ram_q_b. It is not reset.
- Push acceptance:
  - push_ok = wr_en & !full & !rst & !clr.
  - ram_we_a = push_ok, combinational; ram_addr_a = wr_ptr; ram_data_a = wr_data.
  - The RAM writes on the same edge. wr_ptr increments mod 64 on that edge.
- Pop acceptance:
  - pop_ok = rd_en & !empty & !rst & !clr.
  - ram_addr_b = rd_ptr, always driven. rd_ptr increments mod 64 on the edge where pop_ok=1.
  - rd_valid=1 in the following cycle; rd_data = ram_q_b = mem[old rd_ptr].
  - Pop latency is 1 cycle. Back-to-back pops give one valid word per cycle.
- count update: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Flags: full = (count==64), empty = (count==0). Both are registered and derived from the next count.
- Wrap-around: pointers are ADDR_W bits and wrap 63->0 silently. count disambiguates full from empty.
- Simultaneous push+pop:
  - When empty: only the push is accepted; count goes to 1 and rd_valid stays 0 next cycle.
  - When full: only the pop is accepted; count goes to 63 and the write is suppressed (ram_we_a=0).
  - Otherwise: both are accepted and count is unchanged.
- Read-during-write on the same address cannot occur:
  - A non-empty FIFO has wr_ptr != rd_ptr unless full.
  - When full, writes are blocked.
- Push while full, or pop while empty: ignored. No state change, no RAM write, no rd_valid.
- rst or clr asserted mid-operation:
  - Returns to reset state on that edge.
  - An rd_valid that would otherwise fire next cycle is suppressed (rd_valid=0).
  - RAM contents are left in place but are logically discarded.
- ram_we_b is constant 0; ram_data_b is constant 0.

Optional Feature:
- Macro: DPR_FIFO_ERR_EN.
- Defined: adds outputs overflow and underflow, both sticky.
  - overflow sets on a cycle with wr_en & full.
  - underflow sets on a cycle with rd_en & empty.
  - Both clear only on rst or clr. Reset value 0.
  - They do not alter FIFO behaviour.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dpr_pkg holds:
  - constants DPR_ADDR_W=6, DPR_DATA_W=8, DPR_DEPTH=64;
  - typedefs dpr_addr_t, dpr_data_t, dpr_cnt_t (ADDR_W+1 bits).
- Flag and pointer logic stay inline; no internal sub-module.
- Wrapper dpr_fifo_top instantiates dpr_fifo_ctrl plus DualPortRam for integration and test.

Test Plan:
- Reset then idle: after rst, expect empty=1, full=0, count=0, rd_valid=0, ram_we_a=0.
- Push 0x33, 0x44, 0x55, then pop 3 back-to-back: rd_valid high for 3 consecutive cycles with rd_data 0x33, 0x44, 0x55, each one cycle after its pop; count ends at 0 and empty=1.
- Fill 64 words (0x00..0x3F): full=1 and count=64. A 65th push with 0x77 leaves count=64 and ram_we_a=0 (overflow=1 with DPR_FIFO_ERR_EN). Draining returns 0x00..0x3F in order.
- Wrap: push 60 and pop 60 words, then push 10 and pop 10: pointers wrap past 63, and data comes out in order with no corruption.
- Simultaneous push 0xAA + pop:
  - on empty: count goes to 1, no rd_valid;
  - on full: count goes to 63, rd_valid next cycle with the oldest word, and 0xAA is not written;
  - at count=5: count stays 5.
- rst (and separately clr) asserted the same cycle as an accepted pop at count=3: next cycle rd_valid=0, count=0, empty=1; the next push+pop round-trips 0x5A.

Source files
------------

// File: rtl/dpr_pkg.sv
// dpr_pkg: shared constants and types for the DualPortRam FIFO controller.
//   DPR_ADDR_W / DPR_DATA_W / DPR_DEPTH : RAM geometry (64 x 8)
//   dpr_addr_t : RAM address
//   dpr_data_t : RAM data word
//   dpr_cnt_t  : FIFO occupancy, one bit wider than the address (0..64)
package dpr_pkg;

  localparam int DPR_ADDR_W = 6;
  localparam int DPR_DATA_W = 8;
  localparam int DPR_DEPTH  = 2 ** DPR_ADDR_W;

  typedef logic [DPR_ADDR_W-1:0] dpr_addr_t;
  typedef logic [DPR_DATA_W-1:0] dpr_data_t;
  typedef logic [DPR_ADDR_W:0]   dpr_cnt_t;

endpackage

// File: rtl/dpr_fifo_ctrl.sv
// dpr_fifo_ctrl: synchronous FIFO controller driving a DualPortRam.
// Port A of the RAM is write-only and port B is read-only.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   clr                 synchronous flush, same effect as rst on FIFO state
//   wr_en, wr_data      push request and data; full flags a 64-word FIFO
//   rd_en               pop request; rd_data/rd_valid return the word one
//                       cycle later; empty flags a 0-word FIFO
//   count               occupancy 0..64
//   ram_*_a             RAM write port drive (addr, data, we)
//   ram_*_b, ram_q_b    RAM read port drive and registered read data
//   overflow, underflow sticky error flags, present only when the macro
//                       DPR_FIFO_ERR_EN is defined
module dpr_fifo_ctrl
  import dpr_pkg::*;
#(
  parameter int ADDR_W = DPR_ADDR_W,
  parameter int DATA_W = DPR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
`ifdef DPR_FIFO_ERR_EN
  input  logic [DATA_W-1:0] ram_q_b,
  output logic              overflow,
  output logic              underflow
`else
  input  logic [DATA_W-1:0] ram_q_b
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic              flush;

  assign flush   = rst | clr;
  // full blocks the push and empty blocks the pop, so a simultaneous
  // request on an empty or full FIFO degrades to a single operation.
  assign push_ok = wr_en & ~full  & ~flush;
  assign pop_ok  = rd_en & ~empty & ~flush;

  assign ram_we_a   = push_ok;
  assign ram_addr_a = wr_ptr;
  assign ram_data_a = wr_data;
  assign ram_addr_b = rd_ptr;
  assign ram_data_b = '0;
  assign ram_we_b   = 1'b0;

  // The RAM read is already registered, so the popped word is simply q_b
  // during the rd_valid cycle.
  assign rd_data = ram_q_b;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == FULL_CNT);
      rd_valid <= pop_ok;
    end
  end

`ifdef DPR_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
module tb_dpr_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [6:0] count;
  logic [7:0] ram_data_a;
  logic [5:0] ram_addr_a;
  logic       ram_we_a;
  logic [7:0] ram_data_b;
  logic [5:0] ram_addr_b;
  logic       ram_we_b;
  logic [7:0] ram_q_b;
`ifdef DPR_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  dpr_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .count      (count),
    .ram_data_a (ram_data_a),
    .ram_addr_a (ram_addr_a),
    .ram_we_a   (ram_we_a),
    .ram_data_b (ram_data_b),
    .ram_addr_b (ram_addr_b),
    .ram_we_b   (ram_we_b),
`ifdef DPR_FIFO_ERR_EN
    .ram_q_b    (ram_q_b),
    .overflow   (overflow),
    .underflow  (underflow)
`else
    .ram_q_b    (ram_q_b)
`endif
  );

  // Behavioural 64 x 8 DualPortRam: port A writes, port B registered read.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic w, input logic rd,
                       input logic [7:0] d);
    rst = r; clr = c; wr_en = w; rd_en = rd; wr_data = d;
  endtask

  typedef struct {
    logic       r, c, w, rd;
    logic [7:0] d;
    logic       we;
    logic [6:0] cnt;
    logic       emp, ful, rv, chk_d;
    logic [7:0] rdat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic w, input logic rd,
                     input logic [7:0] d, input logic we, input int cnt,
                     input logic emp, input logic ful, input logic rv,
                     input logic chk_d, input logic [7:0] rdat);
    vec_t v;
    v.r = r; v.c = c; v.w = w; v.rd = rd; v.d = d; v.we = we;
    v.cnt = 7'(cnt); v.emp = emp; v.ful = ful; v.rv = rv;
    v.chk_d = chk_d; v.rdat = rdat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] exp_d;
    drive(1, 0, 0, 0, 8'h00);

    //   rst clr wr rd data   we cnt emp ful rv chkd rdat
    add(1, 0, 1, 1, 8'h99, 0, 0, 1, 0, 0, 0, 8'h00);  // reset masks requests
    add(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);  // idle
    add(0, 0, 1, 0, 8'h33, 1, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h44, 1, 2, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h55, 1, 3, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 1, 8'h00, 0, 2, 0, 0, 1, 1, 8'h33);
    add(0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 1, 8'h44);
    add(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h55);
    add(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);
    add(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);  // pop on empty ignored
    add(0, 0, 1, 1, 8'hAA, 1, 1, 0, 0, 0, 0, 8'h00);  // push+pop on empty
    add(0, 0, 1, 0, 8'h01, 1, 2, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h02, 1, 3, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h03, 1, 4, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h04, 1, 5, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 1, 8'hBB, 1, 5, 0, 0, 1, 1, 8'hAA);  // push+pop at count 5
    add(0, 0, 0, 1, 8'h00, 0, 4, 0, 0, 1, 1, 8'h01);
    add(0, 0, 0, 1, 8'h00, 0, 3, 0, 0, 1, 1, 8'h02);
    add(1, 0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);  // rst with pop at count 3
    add(0, 0, 1, 0, 8'h5A, 1, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h5A);
    add(0, 0, 1, 0, 8'h11, 1, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h22, 1, 2, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h33, 1, 3, 0, 0, 0, 0, 8'h00);
    add(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);  // clr with pop at count 3
    add(0, 0, 1, 0, 8'h5A, 1, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h5A);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].c, vecs[i].w, vecs[i].rd, vecs[i].d);
      #1;
      chk($sformatf("vec%0d ram_we_a", i), 32'(ram_we_a), 32'(vecs[i].we));
      if (vecs[i].we) chk($sformatf("vec%0d ram_data_a", i), 32'(ram_data_a), 32'(vecs[i].d));
      cycle();
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].ful));
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      if (vecs[i].chk_d) chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rdat));
    end
    chk("ram_we_b", 32'(ram_we_b), 32'd0);
    chk("ram_data_b", 32'(ram_data_b), 32'd0);

    // Fill 64 words 0x00..0x3F
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 1, 0, 8'(i));
      #1;
      chk($sformatf("fill%0d ram_we_a", i), 32'(ram_we_a), 32'd1);
      cycle();
    end
    drive(0, 0, 0, 0, 8'h00);
    chk("fill full", 32'(full), 32'd1);
    chk("fill count", 32'(count), 32'd64);
    chk("fill empty", 32'(empty), 32'd0);

    // 65th push is blocked
    drive(0, 0, 1, 0, 8'h77);
    #1;
    chk("overpush ram_we_a", 32'(ram_we_a), 32'd0);
    cycle();
    chk("overpush count", 32'(count), 32'd64);
`ifdef DPR_FIFO_ERR_EN
    chk("overflow set", 32'(overflow), 32'd1);
    chk("underflow clear", 32'(underflow), 32'd0);
`endif

    // push 0xAA + pop while full: only the pop happens
    drive(0, 0, 1, 1, 8'hAA);
    #1;
    chk("full push+pop ram_we_a", 32'(ram_we_a), 32'd0);
    cycle();
    chk("full push+pop count", 32'(count), 32'd63);
    chk("full push+pop rd_valid", 32'(rd_valid), 32'd1);
    chk("full push+pop rd_data", 32'(rd_data), 32'h00);
    chk("full push+pop full", 32'(full), 32'd0);

    // drain the remaining 63 words in order
    for (int i = 1; i < 64; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      cycle();
      chk($sformatf("drain%0d rd_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("drain%0d rd_data", i), 32'(rd_data), 32'(i));
    end
    drive(0, 0, 0, 0, 8'h00);
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain count", 32'(count), 32'd0);
    cycle();
    chk("drain idle rd_valid", 32'(rd_valid), 32'd0);

    // Wrap: 60 in / 60 out, then 10 in / 10 out crossing address 63->0
    for (int i = 0; i < 60; i++) begin
      drive(0, 0, 1, 0, 8'(8'h80 + i));
      cycle();
    end
    chk("wrap60 count", 32'(count), 32'd60);
    for (int i = 0; i < 60; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      cycle();
      exp_d = 8'(8'h80 + i);
      chk($sformatf("wrapA%0d rd_data", i), 32'(rd_data), 32'(exp_d));
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, 8'(8'hC0 + i));
      cycle();
    end
    chk("wrap10 count", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      cycle();
      exp_d = 8'(8'hC0 + i);
      chk($sformatf("wrapB%0d rd_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("wrapB%0d rd_data", i), 32'(rd_data), 32'(exp_d));
    end
    chk("wrap empty", 32'(empty), 32'd1);

    // pop on empty then flush; error flags behave as sticky
    drive(0, 0, 0, 1, 8'h00);
    cycle();
    chk("underpop count", 32'(count), 32'd0);
    chk("underpop rd_valid", 32'(rd_valid), 32'd0);
`ifdef DPR_FIFO_ERR_EN
    chk("underflow set", 32'(underflow), 32'd1);
    chk("overflow still set", 32'(overflow), 32'd1);
    drive(0, 1, 0, 0, 8'h00);
    cycle();
    chk("clr overflow", 32'(overflow), 32'd0);
    chk("clr underflow", 32'(underflow), 32'd0);
`endif
    drive(0, 0, 0, 0, 8'h00);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
